// File: rtl/i2s_tx.sv
// I2S transmitter: one-entry sample buffer, clk24-derived BCLK/LRCLK, same sample in both slots.
// Define I2S_TX_LJ_EN for left-justified framing (no 1-bit delay); default is standard I2S.
module i2s_tx #(
  parameter int BCLK_DIV = 4
) (
  input  logic        clk24,
  input  logic        rst,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        underrun_clr,
  output logic        underrun,
  output logic        frame_start,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdata
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             bclk_q, bclk_d;
  logic [5:0]       bit_cnt_q, bit_cnt_d;
  logic             lrclk_q, lrclk_d;
  logic             sdata_q, sdata_d;
  logic             full_q, full_d;
  logic [15:0]      buf_q, buf_d;
  logic [15:0]      cur_q, cur_d;
  logic             underrun_q, underrun_d;

  logic             wrap;
  logic             fall_evt;
  logic             load;
  logic             accept;
  logic [4:0]       slot_k;
  logic             ser_bit;

  // Handshake: in_ready is simply !full. A transfer happens on any rising edge
  // where in_valid & in_ready; the producer must hold in_data while in_valid=1
  // and in_ready=0. In the load cycle with the buffer empty, a valid sample
  // bypasses the buffer straight into cur_sample.
  assign in_ready    = ~full_q;
  assign accept      = in_valid & ~full_q;

  assign wrap        = (div_cnt_q == DIV_LAST);
  assign fall_evt    = wrap & bclk_q;
  assign load        = fall_evt & (bit_cnt_q == 6'd63);

  assign frame_start = load;
  assign underrun    = underrun_q;
  assign i2s_bclk    = bclk_q;
  assign i2s_lrclk   = lrclk_q;
  assign i2s_sdata   = sdata_q;

  always_comb begin
    div_cnt_d = wrap ? '0 : div_cnt_q + DIV_W'(1);
    bclk_d    = wrap ? ~bclk_q : bclk_q;
    bit_cnt_d = fall_evt ? bit_cnt_q + 6'd1 : bit_cnt_q;
  end

  always_comb begin
    full_d     = full_q;
    buf_d      = buf_q;
    cur_d      = cur_q;
    underrun_d = underrun_q;
    if (underrun_clr) begin
      underrun_d = 1'b0;
    end
    if (load) begin
      if (full_q) begin
        cur_d  = buf_q;
        full_d = 1'b0;
      end else if (in_valid) begin
        cur_d = in_data;
      end else begin
        // Set has priority over a coincident clear.
        underrun_d = 1'b1;
      end
    end else if (accept) begin
      buf_d  = in_data;
      full_d = 1'b1;
    end
  end

  // Slot bits come from the post-increment bit count and the post-load sample,
  // so the first data bit of a frame already carries the freshly loaded value.
  always_comb begin
    slot_k  = bit_cnt_d[4:0];
    ser_bit = 1'b0;
`ifdef I2S_TX_LJ_EN
    if (slot_k <= 5'd15) begin
      ser_bit = cur_d[4'(5'd15 - slot_k)];
    end
`else
    if ((slot_k >= 5'd1) && (slot_k <= 5'd16)) begin
      ser_bit = cur_d[4'(5'd16 - slot_k)];
    end
`endif
    lrclk_d = fall_evt ? bit_cnt_d[5] : lrclk_q;
    sdata_d = fall_evt ? ser_bit : sdata_q;
  end

  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) begin
      div_cnt_q  <= '0;
      bclk_q     <= 1'b0;
      bit_cnt_q  <= 6'd63;
      lrclk_q    <= 1'b1;
      sdata_q    <= 1'b0;
      full_q     <= 1'b0;
      buf_q      <= 16'h0000;
      cur_q      <= 16'h0000;
      underrun_q <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      bclk_q     <= bclk_d;
      bit_cnt_q  <= bit_cnt_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      full_q     <= full_d;
      buf_q      <= buf_d;
      cur_q      <= cur_d;
      underrun_q <= underrun_d;
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: frame-level reference model checked every cycle, a frame table,
// and hand-written sequences for backpressure, bypass, underrun priority and mid-frame reset.
module tb_i2s_tx;

  localparam int DIV = 4;
  localparam int FRAME_CYC = 128 * DIV;

  logic        clk;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        underrun_clr;
  logic        underrun;
  logic        frame_start;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_sdata;

  i2s_tx #(.BCLK_DIV(DIV)) dut (
    .clk24        (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .underrun_clr (underrun_clr),
    .underrun     (underrun),
    .frame_start  (frame_start),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrclk    (i2s_lrclk),
    .i2s_sdata    (i2s_sdata)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int ecnt;
  always @(posedge clk or posedge rst) begin
    if (rst) ecnt <= 0;
    else     ecnt <= ecnt + 1;
  end

  // ---------------- scoreboard / reporting ----------------
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ecnt);
  endtask

  task automatic tmo(input string name);
    n_chk++;
    $display("FAIL %s: timed out at cycle %0d", name, ecnt);
  endtask

  function automatic logic exp_sd(input logic [15:0] s, input int b);
    int k;
    k = b % 32;
`ifdef I2S_TX_LJ_EN
    if (k <= 15) return s[15-k];
`else
    if (k >= 1 && k <= 16) return s[16-k];
`endif
    return 1'b0;
  endfunction

  function automatic logic [63:0] frame_word(input logic [15:0] s);
`ifdef I2S_TX_LJ_EN
    return {s, 16'h0000, s, 16'h0000};
`else
    return {1'b0, s, 15'h0000, 1'b0, s, 15'h0000};
`endif
  endfunction

  // ---------------- reference model ----------------
  logic [15:0] exp_q[$];
  logic [15:0] cur_m;
  logic        under_m;
  logic [63:0] cap_acc;
  logic [63:0] cap_w[16];

  task automatic model_step();
    int c, m, b, f;
    logic exp_rdy, ld, set_u;
    if (rst) begin
      exp_q.delete();
      cur_m   = 16'h0000;
      under_m = 1'b0;
      cap_acc = 64'h0;
      for (int i = 0; i < 16; i++) cap_w[i] = 'x;
      chk("rst_bclk", 64'(i2s_bclk), 64'd0);
      chk("rst_lrclk", 64'(i2s_lrclk), 64'd1);
      chk("rst_ready", 64'(in_ready), 64'd1);
      return;
    end
    c = ecnt;
    m = c / (2 * DIV);
    b = (63 + m) % 64;
    chk("bclk", 64'(i2s_bclk), 64'((c / DIV) % 2));
    chk("lrclk", 64'(i2s_lrclk), 64'(b >= 32));
    chk("sdata", 64'(i2s_sdata), 64'(exp_sd(cur_m, b)));
    exp_rdy = (exp_q.size() == 0);
    ld = ((c % FRAME_CYC) == 2 * DIV - 1);
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("frame_start", 64'(frame_start), 64'(ld));
    chk("underrun", 64'(underrun), 64'(under_m));
    // capture what a DAC would see on each BCLK rising edge
    if ((c % (2 * DIV)) == DIV && m >= 1) begin
      cap_acc = {cap_acc[62:0], i2s_sdata};
      if (((m - 1) % 64) == 63) begin
        f = (m - 1) / 64;
        if (f < 16) cap_w[f] = cap_acc;
      end
    end
    if (in_valid && exp_rdy) exp_q.push_back(in_data);
    set_u = 1'b0;
    if (ld) begin
      if (exp_q.size() > 0) cur_m = exp_q.pop_front();
      else set_u = 1'b1;
    end
    if (set_u) under_m = 1'b1;
    else if (underrun_clr) under_m = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      model_step();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic to_cycle(input int n);
    int g;
    g = 0;
    while (ecnt < n && g < 20000) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (ecnt < n) tmo("to_cycle");
  endtask

  task automatic give(input logic [15:0] s);
    int g;
    logic acc;
    in_data  = s;
    in_valid = 1'b1;
    g = 0;
    acc = 1'b0;
    while (!acc && g < 3000) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      g++;
    end
    in_valid = 1'b0;
    if (!acc) tmo("give");
  endtask

  // ---------------- frame table ----------------
  typedef struct {
    bit          give;
    logic [15:0] smp;
    logic [15:0] exp_sent;
    bit          exp_under;
    bit          clr;
  } row_t;

  row_t tbl[8];

  initial begin
    int xfers;
    logic acc;
    tbl[0] = '{1'b1, 16'h8001, 16'h8001, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 16'h0000, 16'hFFFF, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 16'h0000, 16'hFFFF, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 16'h5A3C, 16'h5A3C, 1'b1, 1'b1};
    tbl[7] = '{1'b1, 16'hA5A5, 16'hA5A5, 1'b0, 1'b0};

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 16'h0000;
    underrun_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("init_bclk", 64'(i2s_bclk), 64'd0);
    chk("init_lrclk", 64'(i2s_lrclk), 64'd1);
    chk("init_sdata", 64'(i2s_sdata), 64'd0);
    chk("init_ready", 64'(in_ready), 64'd1);
    chk("init_under", 64'(underrun), 64'd0);
    chk("init_fs", 64'(frame_start), 64'd0);

    // Backpressure: in_valid held high, one transfer per frame once the buffer is busy
    do_reset();
    in_data = 16'h1111;
    in_valid = 1'b1;
    xfers = 0;
    while (ecnt < 1100) begin
      @(negedge clk);
      acc = in_ready;
      if (ecnt == 6) chk("fs_before_load", 64'(frame_start), 64'd0);
      if (ecnt == 7) begin
        chk("bp_ready_in_load", 64'(in_ready), 64'd0);
        chk("fs_first_load", 64'(frame_start), 64'd1);
      end
      if (ecnt == 8) chk("bp_ready_after_load", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      if (acc) begin
        xfers++;
        in_data = in_data + 16'h0101;
      end
    end
    in_valid = 1'b0;
    chk("bp_xfers", 64'(xfers), 64'd4);
    chk("bp_frame0", cap_w[0], frame_word(16'h1111));
    chk("bp_frame1", cap_w[1], frame_word(16'h1212));

    // Bypass: sample offered only in the load cycle with the buffer empty
    do_reset();
    to_cycle(7);
    in_data = 16'h1234;
    in_valid = 1'b1;
    to_cycle(8);
    in_valid = 1'b0;
    to_cycle(100);
    chk("byp_under", 64'(underrun), 64'd0);
    to_cycle(520);
    chk("byp_frame0", cap_w[0], frame_word(16'h1234));

    // Underrun set wins over a coincident clear
    do_reset();
    to_cycle(100);
    chk("sw_under_set", 64'(underrun), 64'd1);
    to_cycle(519);
    underrun_clr = 1'b1;
    to_cycle(520);
    underrun_clr = 1'b0;
    chk("sw_set_wins", 64'(underrun), 64'd1);
    to_cycle(600);
    underrun_clr = 1'b1;
    to_cycle(601);
    underrun_clr = 1'b0;
    chk("sw_cleared", 64'(underrun), 64'd0);
    chk("sw_frame0", cap_w[0], frame_word(16'h0000));

    // Mid-frame reset at bit_cnt=40 with a sample still held in the buffer
    do_reset();
    give(16'hBDEF);
    give(16'hC0DE);
    to_cycle(333);
    chk("pre_bclk", 64'(i2s_bclk), 64'd1);
    chk("pre_lrclk", 64'(i2s_lrclk), 64'd1);
    chk("pre_sdata", 64'(i2s_sdata), 64'd1);
    chk("pre_ready", 64'(in_ready), 64'd0);
    #1;
    rst = 1'b1;
    #1;
    chk("mr_bclk", 64'(i2s_bclk), 64'd0);
    chk("mr_lrclk", 64'(i2s_lrclk), 64'd1);
    chk("mr_sdata", 64'(i2s_sdata), 64'd0);
    chk("mr_ready", 64'(in_ready), 64'd1);
    chk("mr_under", 64'(underrun), 64'd0);
    chk("mr_fs", 64'(frame_start), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    to_cycle(100);
    chk("mr_under_after", 64'(underrun), 64'd1);
    to_cycle(520);
    chk("mr_frame0", cap_w[0], frame_word(16'h0000));

    // Table-driven frames: one row per frame
    do_reset();
    for (int j = 0; j < 8; j++) begin
      if (j > 0) to_cycle(FRAME_CYC * j - 200);
      if (tbl[j].give) give(tbl[j].smp);
      to_cycle(FRAME_CYC * j + 100);
      chk($sformatf("tbl_under_%0d", j), 64'(underrun), 64'(tbl[j].exp_under));
      if (tbl[j].clr) begin
        underrun_clr = 1'b1;
        to_cycle(FRAME_CYC * j + 101);
        underrun_clr = 1'b0;
        to_cycle(FRAME_CYC * j + 103);
        chk($sformatf("tbl_clr_%0d", j), 64'(underrun), 64'd0);
      end
    end
    to_cycle(FRAME_CYC * 8 + 10);
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("tbl_frame_%0d", j), cap_w[j], frame_word(tbl[j].exp_sent));
    end

    // Random producer: random samples at random points in each frame
    do_reset();
    for (int j = 0; j < 6; j++) begin
      to_cycle(FRAME_CYC * j + 20 + int'($urandom_range(0, 400)));
      if ($urandom_range(0, 3) != 0) give(16'($urandom));
    end
    to_cycle(FRAME_CYC * 6 + 10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Audio sink for the synth voice path. Accepts 16-bit signed mono samples on a valid/ready handshake and serialises them to an external DAC as I2S (BCLK, LRCLK, SDATA), all derived from clk24.
- The same sample is sent on the left and right slots.
- A one-entry holding buffer decouples the producer from frame timing.
- Underrun is flagged; the last sample is repeated.

Parameters:
- BCLK_DIV, 4, clk24 cycles per BCLK half-period; legal values ≥2. Default gives BCLK = 3 MHz and fs = 46.875 kHz.

Ports:
- clk24  in  1  system clock; all logic is on its rising edge
- rst  in  1  asynchronous reset, active-high
- in_data  in  16  signed sample (two's complement)
- in_valid  in  1  in_data is valid
- in_ready  out  1  holding buffer empty; the sample is accepted when in_valid and in_ready are both high
- underrun_clr  in  1  clears the underrun flag
- underrun  out  1  sticky: a frame started with no new sample
- frame_start  out  1  one-cycle pulse on each frame load
- i2s_bclk  out  1  bit clock
- i2s_lrclk  out  1  word select; 0 = left, 1 = right
- i2s_sdata  out  1  serial data, MSB first

Behaviour:
- Reset values: div_cnt=0, bit_cnt=63, i2s_bclk=0, i2s_lrclk=1, i2s_sdata=0, buffer empty (in_ready=1), cur_sample=0, underrun=0, frame_start=0.
- Divider:
  - div_cnt counts 0..BCLK_DIV-1 and wraps.
  - On each wrap, i2s_bclk toggles.
  - A "fall event" is a wrap while i2s_bclk=1.
  - Bit period is 2*BCLK_DIV clk24 cycles; a frame is 64 bits (128*BCLK_DIV cycles).
- Bit counter: on each fall event, bit_cnt <= bit_cnt+1 mod 64. lrclk and sdata are registered on the same edge from the new bit_cnt, so they change with BCLK falling, and the DAC samples on BCLK rising.
- LRCLK: 0 when new bit_cnt is 0..31, 1 when it is 32..63.
- SDATA, with k = new bit_cnt mod 32:
  - k in 1..16: cur_sample[16-k]. This is standard I2S with a 1-bit delay; the MSB is at k=1.
  - otherwise: 0.
- Frame load: occurs on the fall event where bit_cnt wraps 63->0. The first fall event after reset is at cycle 2*BCLK_DIV. In that same cycle:
  - Buffer full: cur_sample <= buffer; buffer empties.
  - Buffer empty and in_valid=1: bypass. cur_sample <= in_data, the handshake completes, and there is no underrun.
  - Buffer empty and in_valid=0: cur_sample is unchanged and underrun <= 1.
  - frame_start=1 for that cycle only.
- The frame-load update takes effect at the same edge as the k=0 slot. The MSB at k=1 therefore already uses the new sample.
- Handshake:
  - in_ready = !full (combinational from the full flag).
  - A sample is accepted when in_valid & in_ready; the buffer becomes full next cycle.
  - in_data must be held stable while in_valid=1 and in_ready=0.
  - When full, a new sample is not accepted in the load cycle. in_ready rises the cycle after the load.
- Underrun:
  - Set by a load with no data; held until underrun_clr=1.
  - If clear and set happen in the same cycle, set wins.
- Reset asserted mid-frame: all state returns immediately to the reset values (async). The partial frame is abandoned and the held sample is discarded.
- Arithmetic: the sample is passed bit-exact. There is no scaling, rounding or sign extension; bits 17..31 of each slot are 0.

Optional Feature:
- Macro I2S_TX_LJ_EN selects left-justified mode.
- Defined: left-justified format with no 1-bit delay. SDATA for k in 0..15 is cur_sample[15-k], otherwise 0. The frame load still occurs on the 63->0 fall event, so the MSB at k=0 is the new sample.
- Undefined: standard I2S as above.

Test Plan:
- Reset, then drive in_data=16'h8001 valid before the first frame. Required: frame_start at cycle 8. LRCLK=0 for 32 bits. SDATA reads 1000_0000_0000_0001 on BCLK rising edges at left-slot bits 1..16 and again at right-slot bits 33..48, with zeros elsewhere.
- Continuous producer, one sample per frame, with values 16'h7FFF, 16'h0000, 16'hFFFF. Required: each value appears in consecutive frames, underrun stays 0, and frame_start pulses are 512 cycles apart (BCLK_DIV=4).
- No sample supplied for the second frame. Required: underrun=1 from that load onward and the previous sample is repeated. Pulsing underrun_clr clears it, while a clear coincident with a new underrun leaves it at 1.
- in_valid held high with the buffer full. Required: in_ready=0 until the cycle after the load, and exactly one transfer per frame. Bypass case: present 16'h1234 only in the load cycle with the buffer empty; it is sent in that frame with no underrun.
- Assert rst mid right slot (bit_cnt=40). Required: outputs go to the reset values immediately, and the next frame sends 16'h0000 if no sample is given.
- With I2S_TX_LJ_EN defined and in_data=16'hA5A5: the MSB appears at bit 0 and bit 32, with pattern 1010_0101_1010_0101.
